nrs_gold_gen_tx: RTL and testbench
==================================

// Module: nrs_gold_gen_tx
// PURPOSE
//  Writer side of the TX NRS bit register: Gold-sequence (31-bit LFSR pair) generator producing c(n), n=0..WIDTH_REG-1.
//  Bits are written serially (c_n, wr_en, wr_addr) into the NRS register, where the mapper reads them as QPSK bit pairs.
//  Runs once per start pulse; c_init (per slot/symbol/N_ID) is computed upstream and held stable.
// PARAMETERS
//  WIDTH_REG  16                 number of c(n) bits generated per run (= NRS register depth)
//  LINES      $clog2(WIDTH_REG)  write-address width
//  NC         1600               warm-up shifts discarded before c(0); must be a multiple of 8
// PORTS
//  clk      in   1      single system clock, rising edge
//  rst      in   1      asynchronous, active-low reset
//  start    in   1      one-cycle request; sampled only in IDLE
//  c_init   in   31     x2 initial state; sampled on the accepted start edge
//  c_n      out  1      generated bit, valid when wr_en=1
//  wr_en    out  1      write strobe to the NRS register
//  wr_addr  out  LINES  bit index n of c_n
//  busy     out  1      high from the accepted start through the last write
//  done     out  1      one-cycle pulse after the last write
// BEHAVIOUR
//  Reset: all outputs 0; x1, x2, counters = 0; state IDLE. Reset mid-run aborts immediately; there is no partial resume.
//  x1(n+31) = x1(n+3) ^ x1(n);  x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n);  c(n) = x1(n+NC) ^ x2(n+NC)
//  Register LSB holds the oldest bit. Shift right; the new bit enters bit 30.
//  States:
//   IDLE:   start=1 -> load x1 = 31'd1 and x2 = c_init, clear cnt, busy <= 1, go to WARMUP.
//   WARMUP: advance both LFSRs one step per cycle. After NC steps -> GEN, k = 0.
//   GEN:    each cycle register c_n <= x1[0]^x2[0], wr_en <= 1, wr_addr <= k; shift both LFSRs; k++.
//           After the k = WIDTH_REG-1 write -> DONE.
//   DONE:   wr_en <= 0, busy <= 0, done <= 1 for one cycle, then IDLE.
//  Latency: if start is accepted at edge E, the first wr_en=1 is visible after edge E+NC+1.
//   wr_en stays high for exactly WIDTH_REG consecutive cycles; done is high in the cycle after the last write.
//  wr_addr counts 0..WIDTH_REG-1 monotonically and never wraps within a run.
//   wr_addr and c_n hold their last values while wr_en=0.
//  start outside IDLE (including the DONE cycle) is ignored. c_init changes after acceptance have no effect.
//  Back-to-back runs: start in the cycle after done is accepted normally.
// CONFIGURATION
//  NRS_GOLD_WARMUP_X8_EN defined: WARMUP advances both LFSRs 8 steps per cycle; NC/8 warm-up cycles.
//   First wr_en is visible after edge E+NC/8+1.
//  Not defined: 1 step per cycle as above.
//  GEN is always 1 bit per cycle, and c(n) values are identical in both builds.
// STRUCTURE
//  Shared package nrs_pkg:
//   - constants NC_DEFAULT=1600, LFSR_LEN=31, X1_INIT=31'd1
//   - tap masks for x1 and x2
//   - state encoding IDLE/WARMUP/GEN/DONE (2-bit)
//  Sub-module nrs_gold_lfsr_step: combinational next-state for one x1/x2 step, parameterised by tap mask.
//   The top instantiates it once per step (1 instance, or 8 chained instances under NRS_GOLD_WARMUP_X8_EN).
//  Top holds the FSM, the 11-bit warm-up counter, the LINES-bit k counter and the registered outputs.
// TESTING
//  Reference model: bit-accurate 31-bit Gold model run to n = NC+WIDTH_REG; scoreboard compares every write.
//  1 Reset, then idle 20 cycles -> all outputs 0, no wr_en pulse.
//  2 c_init=0, start at edge E -> first wr_en after edge E+1601; 16 writes, addr 0..15.
//     c_n equals the model's x1-only sequence; done pulses once; busy is high for exactly 1601+16 cycles.
//  3 c_init=31'h12345 and 31'h7FFFFFFF -> all 16 bits match the model.
//     Rerun with the X8 macro -> identical bits, first wr_en at E+201.
//  4 Start pulses during WARMUP, GEN and DONE -> ignored: exactly 16 writes, one done.
//     Changing c_init mid-run -> no effect on c_n.
//  5 rst asserted during GEN at k=7 -> outputs 0 immediately.
//     Fresh start after release -> full correct 16-bit run from addr 0.
//  6 Back-to-back: start in the cycle after done with a new c_init -> second run correct.
//     Integrate with the NRS register: the mapper reads match model bits c(0..15).

Source files
------------

// File: rtl/nrs_pkg.sv
// ============================================================================
// Module  : nrs_pkg
// Brief   : Shared constants, LFSR tap masks and FSM encoding for the NRS Gold generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package nrs_pkg;

    localparam int          NC_DEFAULT = 1600;
    localparam int          LFSR_LEN   = 31;
    localparam logic [30:0] X1_INIT    = 31'd1;

    // Feedback taps in the shift-right form: bit i holds x(n+i).
    localparam logic [30:0] X1_TAPS    = 31'h0000_0009;
    localparam logic [30:0] X2_TAPS    = 31'h0000_000F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_GEN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/nrs_gold_lfsr_step.sv
// ============================================================================
// Module  : nrs_gold_lfsr_step
// Brief   : One combinational step of a 31-bit Fibonacci LFSR (shift right, new bit at MSB).
// Revision: 1.0
// ============================================================================
`default_nettype none

module nrs_gold_lfsr_step
    import nrs_pkg::*;
#(
    parameter logic [LFSR_LEN-1:0] TAPS = X1_TAPS
) (
    input  logic [LFSR_LEN-1:0] cur,
    output logic [LFSR_LEN-1:0] nxt
);

    assign nxt = {^(cur & TAPS), cur[LFSR_LEN-1:1]};

endmodule

`default_nettype wire

// File: rtl/nrs_gold_gen_tx.sv
// ============================================================================
// Module  : nrs_gold_gen_tx
// Brief   : Gold-sequence c(n) generator writing WIDTH_REG bits serially into the TX NRS register.
//           NRS_GOLD_WARMUP_X8_EN: warm-up advances the LFSRs 8 steps per cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nrs_gold_gen_tx
    import nrs_pkg::*;
#(
    parameter int WIDTH_REG = 16,
    parameter int LINES     = $clog2(WIDTH_REG),
    parameter int NC        = NC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [30:0]      c_init,
    output logic             c_n,
    output logic             wr_en,
    output logic [LINES-1:0] wr_addr,
    output logic             busy,
    output logic             done
);

`ifdef NRS_GOLD_WARMUP_X8_EN
    localparam int STEPS = 8;
`else
    localparam int STEPS = 1;
`endif

    localparam int               WARM_CYCLES = NC / STEPS;
    localparam logic [10:0]      WARM_LAST   = 11'(WARM_CYCLES - 1);
    localparam logic [LINES-1:0] K_LAST      = LINES'(WIDTH_REG - 1);

    state_t             r_state;
    logic [30:0]        r_x1;
    logic [30:0]        r_x2;
    logic [10:0]        r_warm;
    logic [LINES-1:0]   r_k;

    logic [30:0]        w_x1_chain [0:STEPS];
    logic [30:0]        w_x2_chain [0:STEPS];

    assign w_x1_chain[0] = r_x1;
    assign w_x2_chain[0] = r_x2;

    // Chain index 1 is the single step used in GEN; index STEPS is the warm-up advance.
    generate
        for (genvar i = 0; i < STEPS; i++) begin : g_step
            nrs_gold_lfsr_step #(.TAPS(X1_TAPS)) u_x1 (
                .cur (w_x1_chain[i]),
                .nxt (w_x1_chain[i+1])
            );
            nrs_gold_lfsr_step #(.TAPS(X2_TAPS)) u_x2 (
                .cur (w_x2_chain[i]),
                .nxt (w_x2_chain[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_x1    <= '0;
            r_x2    <= '0;
            r_warm  <= '0;
            r_k     <= '0;
            c_n     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_x1    <= X1_INIT;
                        r_x2    <= c_init;
                        r_warm  <= '0;
                        r_k     <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_WARMUP;
                    end
                end
                ST_WARMUP: begin
                    r_x1   <= w_x1_chain[STEPS];
                    r_x2   <= w_x2_chain[STEPS];
                    r_warm <= r_warm + 11'd1;
                    if (r_warm == WARM_LAST) begin
                        r_state <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    c_n     <= r_x1[0] ^ r_x2[0];
                    wr_en   <= 1'b1;
                    wr_addr <= r_k;
                    r_x1    <= w_x1_chain[1];
                    r_x2    <= w_x2_chain[1];
                    r_k     <= r_k + LINES'(1);
                    if (r_k == K_LAST) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    wr_en   <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nrs_gold_gen_tx.sv
// ============================================================================
// Module  : tb_nrs_gold_gen_tx
// Brief   : Directed self-checking bench for nrs_gold_gen_tx against a recurrence-form Gold model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nrs_gold_gen_tx;

    localparam int WIDTH_REG = 16;
    localparam int LINES     = 4;
    localparam int NC        = 1600;
`ifdef NRS_GOLD_WARMUP_X8_EN
    localparam int WARM = NC / 8;
`else
    localparam int WARM = NC;
`endif
    localparam int BUDGET = WARM + 200;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [30:0]      c_init;
    logic             c_n;
    logic             wr_en;
    logic [LINES-1:0] wr_addr;
    logic             busy;
    logic             done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit   mon_bits  [$];
    int   mon_addrs [$];
    int   mon_cycs  [$];
    int   done_cnt;
    int   done_cyc;
    int   busy_cnt;
    logic [WIDTH_REG-1:0] nrs_reg;

    nrs_gold_gen_tx #(.WIDTH_REG(WIDTH_REG), .LINES(LINES), .NC(NC)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .c_init  (c_init),
        .c_n     (c_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en) nrs_reg[wr_addr] <= c_n;
    end

    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                mon_bits.push_back(c_n);
                mon_addrs.push_back(int'(wr_addr));
                mon_cycs.push_back(cyc);
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (busy) busy_cnt = busy_cnt + 1;
        end
    end

    // Gold model written directly from the sequence recurrences.
    function automatic logic [WIDTH_REG-1:0] gold(input logic [30:0] init);
        bit x1 [NC+WIDTH_REG+31];
        bit x2 [NC+WIDTH_REG+31];
        logic [WIDTH_REG-1:0] c;
        for (int i = 0; i < 31; i++) begin
            x1[i] = (i == 0);
            x2[i] = init[i];
        end
        for (int n = 0; n + 31 < NC + WIDTH_REG + 31; n++) begin
            x1[n+31] = x1[n+3] ^ x1[n];
            x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
        end
        for (int n = 0; n < WIDTH_REG; n++) c[n] = x1[n+NC] ^ x2[n+NC];
        return c;
    endfunction

    function automatic logic [WIDTH_REG-1:0] got_word(input int base);
        logic [WIDTH_REG-1:0] w;
        w = 'x;
        for (int i = 0; i < WIDTH_REG; i++)
            if (base + i < mon_bits.size()) w[i] = mon_bits[base+i];
        return w;
    endfunction

    function automatic bit addr_seq_ok(input int base);
        if (mon_addrs.size() < base + WIDTH_REG) return 1'b0;
        for (int i = 0; i < WIDTH_REG; i++)
            if (mon_addrs[base+i] != i || mon_cycs[base+i] != mon_cycs[base] + i) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_mon();
        mon_bits.delete();
        mon_addrs.delete();
        mon_cycs.delete();
        done_cnt = 0;
        done_cyc = 0;
        busy_cnt = 0;
    endtask

    task automatic pulse_start(input logic [30:0] init, output int e);
        @(negedge clk);
        start  = 1'b1;
        c_init = init;
        @(negedge clk);
        start  = 1'b0;
        e      = cyc;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        start  = 1'b0;
        c_init = '0;
        repeat (3) @(negedge clk);
        n_assert++;
        if ({c_n, wr_en, wr_addr, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want 0", {c_n, wr_en, wr_addr, busy, done});
        end
        rst = 1'b1;
        clear_mon();
        repeat (20) @(negedge clk);
        #1;
        n_assert++;
        if (mon_bits.size() != 0 || done_cnt != 0 || busy_cnt != 0) begin
            n_fail++;
            $display("FAIL idle_quiet: writes %0d done %0d busy %0d, want 0 0 0",
                     mon_bits.size(), done_cnt, busy_cnt);
        end
        n_assert++;
        if ({c_n, wr_en, wr_addr, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %b, want 0", {c_n, wr_en, wr_addr, busy, done});
        end
    endtask

    task automatic test_zero_init();
        int e;
        bit ok;
        clear_mon();
        pulse_start(31'd0, e);
        wait_done(ok);
        repeat (3) @(negedge clk);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL zero_timeout: done not seen within %0d cycles", BUDGET);
        end
        n_assert++;
        if (got_word(0) !== gold(31'd0)) begin
            n_fail++;
            $display("FAIL zero_bits: got %h, want %h", got_word(0), gold(31'd0));
        end
        n_assert++;
        if (addr_seq_ok(0) !== 1'b1 || mon_bits.size() != WIDTH_REG) begin
            n_fail++;
            $display("FAIL zero_addr: writes %0d, addr/cycle sequence ok=%0d, want %0d writes ok=1",
                     mon_bits.size(), addr_seq_ok(0), WIDTH_REG);
        end
        n_assert++;
        if (mon_cycs.size() == 0 || mon_cycs[0] - e != WARM + 1) begin
            n_fail++;
            $display("FAIL zero_latency: first write %0d cycles after start, want %0d",
                     (mon_cycs.size() == 0) ? -1 : mon_cycs[0] - e, WARM + 1);
        end
        n_assert++;
        if (busy_cnt != WARM + WIDTH_REG + 1) begin
            n_fail++;
            $display("FAIL zero_busy: busy %0d cycles, want %0d", busy_cnt, WARM + WIDTH_REG + 1);
        end
        n_assert++;
        if (done_cnt != 1 || done_cyc - e != WARM + WIDTH_REG + 1) begin
            n_fail++;
            $display("FAIL zero_done: count %0d at +%0d, want 1 at +%0d",
                     done_cnt, done_cyc - e, WARM + WIDTH_REG + 1);
        end
    endtask

    task automatic test_patterns();
        logic [30:0] pats [3];
        int e;
        bit ok;
        pats[0] = 31'h0001_2345;
        pats[1] = 31'h7FFF_FFFF;
        pats[2] = 31'h2A5A_C3F0;
        for (int p = 0; p < 3; p++) begin
            clear_mon();
            pulse_start(pats[p], e);
            wait_done(ok);
            repeat (3) @(negedge clk);
            n_assert++;
            if (!ok || got_word(0) !== gold(pats[p]) || addr_seq_ok(0) !== 1'b1) begin
                n_fail++;
                $display("FAIL pattern_%0d: c_init %h got %h addr_ok %0d, want %h addr_ok 1",
                         p, pats[p], got_word(0), addr_seq_ok(0), gold(pats[p]));
            end
            n_assert++;
            if (mon_cycs.size() == 0 || mon_cycs[0] - e != WARM + 1) begin
                n_fail++;
                $display("FAIL pattern_%0d_latency: got %0d, want %0d", p,
                         (mon_cycs.size() == 0) ? -1 : mon_cycs[0] - e, WARM + 1);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [30:0] a;
        int e;
        a = 31'h1357_9BDF;
        clear_mon();
        pulse_start(a, e);
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) break;
            if (i == 50) c_init = 31'($urandom);
            if (i == 100 || (wr_en && (wr_addr == 4'd3 || wr_addr == 4'd15))) begin
                start  = 1'b1;
                c_init = 31'($urandom);
            end
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        n_assert++;
        if (mon_bits.size() != WIDTH_REG || done_cnt != 1) begin
            n_fail++;
            $display("FAIL ignore_counts: writes %0d done %0d, want %0d 1",
                     mon_bits.size(), done_cnt, WIDTH_REG);
        end
        n_assert++;
        if (got_word(0) !== gold(a) || addr_seq_ok(0) !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_bits: got %h, want %h", got_word(0), gold(a));
        end
    endtask

    task automatic test_reset_mid_run();
        int e;
        bit ok;
        clear_mon();
        pulse_start(31'h0ABC_DEF1, e);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk);
            if (wr_en && wr_addr == 4'd7) begin
                ok = 1'b1;
                break;
            end
        end
        rst = 1'b0;
        #1;
        n_assert++;
        if (!ok || {c_n, wr_en, wr_addr, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: reached k7=%0d outputs %b, want 1 and 0",
                     ok, {c_n, wr_en, wr_addr, busy, done});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
        pulse_start(31'h3300_00CC, e);
        wait_done(ok);
        repeat (3) @(negedge clk);
        n_assert++;
        if (!ok || got_word(0) !== gold(31'h3300_00CC) || addr_seq_ok(0) !== 1'b1
            || mon_bits.size() != WIDTH_REG) begin
            n_fail++;
            $display("FAIL midreset_rerun: got %h writes %0d, want %h writes %0d",
                     got_word(0), mon_bits.size(), gold(31'h3300_00CC), WIDTH_REG);
        end
    endtask

    task automatic test_back_to_back();
        logic [30:0] a;
        logic [30:0] b;
        logic [WIDTH_REG-1:0] exp_b;
        int e1;
        int e2;
        bit ok1;
        bit ok2;
        a = 31'h0246_8ACE;
        b = 31'h5555_0001;
        exp_b = gold(b);
        clear_mon();
        pulse_start(a, e1);
        wait_done(ok1);
        pulse_start(b, e2);
        wait_done(ok2);
        repeat (3) @(negedge clk);
        n_assert++;
        if (!ok1 || !ok2 || mon_bits.size() != 2 * WIDTH_REG || done_cnt != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: done1 %0d done2 %0d writes %0d dones %0d, want 1 1 %0d 2",
                     ok1, ok2, mon_bits.size(), done_cnt, 2 * WIDTH_REG);
        end
        n_assert++;
        if (got_word(0) !== gold(a)) begin
            n_fail++;
            $display("FAIL b2b_run1: got %h, want %h", got_word(0), gold(a));
        end
        n_assert++;
        if (got_word(WIDTH_REG) !== exp_b || addr_seq_ok(WIDTH_REG) !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_run2: got %h, want %h", got_word(WIDTH_REG), exp_b);
        end
        n_assert++;
        if (mon_cycs.size() <= WIDTH_REG || mon_cycs[WIDTH_REG] - e2 != WARM + 1) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d, want %0d",
                     (mon_cycs.size() <= WIDTH_REG) ? -1 : mon_cycs[WIDTH_REG] - e2, WARM + 1);
        end
        for (int q = 0; q < WIDTH_REG / 2; q++) begin
            n_assert++;
            if ({nrs_reg[2*q+1], nrs_reg[2*q]} !== {exp_b[2*q+1], exp_b[2*q]}) begin
                n_fail++;
                $display("FAIL mapper_pair_%0d: got %b%b, want %b%b", q,
                         nrs_reg[2*q+1], nrs_reg[2*q], exp_b[2*q+1], exp_b[2*q]);
            end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_zero_init();
        test_patterns();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
